// File: rtl/temp_display.sv
// Time-multiplexed 4-digit seven-segment driver for the thermostat entry digits.
// Shadow-captures the inputs once per frame, blinks the edited digit, blanks leading zeros.
module temp_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 12500000,
  parameter int GUARD       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] huns,
  input  logic [1:0] input_state,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    ST_ONES = 2'd0,
    ST_TENS = 2'd1,
    ST_HUNS = 2'd2,
    ST_DONE = 2'd3
  } entry_t;

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] GUARD_CNT    = RW'(GUARD);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [RW-1:0] r_refreshCnt;
  logic [1:0]    r_scanIdx;
  logic [BW-1:0] r_blinkCnt;
  logic          r_blinkPhase;
  logic [3:0]    r_shOnes;
  logic [3:0]    r_shTens;
  logic [3:0]    r_shHuns;
  entry_t        r_shState;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_an;
  logic          r_frameTick;

  logic          w_refreshWrap;
  logic          w_frameWrap;
  logic          w_blinkWrap;
  logic          w_inGuard;
  logic          w_isDone;
  logic          w_blinkBlank;
  logic          w_lzBlank;
  logic [3:0]    w_digit;
  logic [6:0]    w_digitSeg;
  logic [6:0]    w_glyph;
  logic          w_dpN;

  function automatic logic [6:0] decodeDigit(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = SEG_DASH;
    endcase
    return pattern;
  endfunction

  assign w_refreshWrap = (r_refreshCnt == REFRESH_LAST);
  assign w_frameWrap   = w_refreshWrap && (r_scanIdx == 2'd3);
  assign w_blinkWrap   = (r_blinkCnt == BLINK_LAST);
  assign w_inGuard     = (r_refreshCnt < GUARD_CNT);
  assign w_isDone      = (r_shState == ST_DONE);

  // Slot counter and scan position; one full frame is four slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refreshCnt <= '0;
      r_scanIdx    <= 2'd0;
    end else if (w_refreshWrap) begin
      r_refreshCnt <= '0;
      r_scanIdx    <= r_scanIdx + 2'd1;
    end else begin
      r_refreshCnt <= r_refreshCnt + RW'(1);
    end
  end

  // Inputs are sampled only at the frame boundary so a frame never mixes old and new digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shOnes    <= 4'd0;
      r_shTens    <= 4'd0;
      r_shHuns    <= 4'd0;
      r_shState   <= ST_ONES;
      r_frameTick <= 1'b0;
    end else begin
      r_frameTick <= w_frameWrap;
      if (w_frameWrap) begin
        r_shOnes  <= ones;
        r_shTens  <= tens;
        r_shHuns  <= huns;
        r_shState <= entry_t'(input_state);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (w_blinkWrap) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= ~r_blinkPhase;
    end else begin
      r_blinkCnt <= r_blinkCnt + BW'(1);
    end
  end

  always_comb begin
    w_digit = 4'd0;
    case (r_scanIdx)
      2'd0:    w_digit = r_shOnes;
      2'd1:    w_digit = r_shTens;
      2'd2:    w_digit = r_shHuns;
      default: w_digit = 4'd0;
    endcase
  end

  assign w_digitSeg   = decodeDigit(w_digit);
  assign w_blinkBlank = r_blinkPhase && !w_isDone && (r_scanIdx == 2'(r_shState));
  // The ones digit is never a leading zero, so "000" still shows a single 0.
  assign w_lzBlank    = blank_lz && w_isDone &&
                        (((r_scanIdx == 2'd2) && (r_shHuns == 4'd0)) ||
                         ((r_scanIdx == 2'd1) && (r_shHuns == 4'd0) && (r_shTens == 4'd0)));

  always_comb begin
    w_glyph = w_digitSeg;
    if (r_scanIdx == 2'd3) begin
      w_glyph = SEG_C;
    end else if (w_blinkBlank || w_lzBlank) begin
      w_glyph = SEG_BLANK;
    end
  end

  assign w_dpN = !((r_scanIdx == 2'd3) && w_isDone);

  // Anodes stay off for the first GUARD cycles of each slot so the previous glyph cannot ghost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
      r_an  <= 4'hF;
    end else if (w_inGuard) begin
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
      r_an  <= 4'hF;
    end else begin
      r_seg <= w_glyph;
      r_dp  <= w_dpN;
      r_an  <= ~(4'b0001 << r_scanIdx);
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_tick = r_frameTick;

endmodule

// File: tb/tb_temp_display.sv
// Scoreboard bench for temp_display: a timing model indexed by cycles since reset
// predicts every output cycle; predictions are queued on drive and popped on output.
module tb_temp_display;

  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 32;
  localparam int GUARD       = 1;
  localparam int FRAME       = 4 * REFRESH_DIV;

  logic       clk;
  logic       rst;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] huns;
  logic [1:0] input_state;
  logic       blank_lz;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

  temp_display #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLINK_DIV  (BLINK_DIV),
    .GUARD      (GUARD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ones       (ones),
    .tens       (tens),
    .huns       (huns),
    .input_state(input_state),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  int checks = 0;
  int passes = 0;
  int k = 0;
  logic [3:0] mOnes, mTens, mHuns;
  logic [1:0] mState;
  logic [12:0] expQ[$];
  logic [6:0] glyphTab [16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("[TB] FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    else
      passes++;
  endtask

  // Output after edge kk comes from the counter state before that edge (index kk-1).
  function automatic logic [12:0] modelOut(input int kk, input logic blz);
    int s, cnt, idx, ph;
    logic [6:0] sg;
    logic d;
    logic [3:0] a;
    logic [3:0] v;
    logic ft;
    s   = kk - 1;
    cnt = s % REFRESH_DIV;
    idx = (s / REFRESH_DIV) % 4;
    ph  = (s / BLINK_DIV) % 2;
    ft  = (kk % FRAME == 0);
    if (cnt < GUARD) begin
      sg = 7'h7F; d = 1'b1; a = 4'hF;
    end else begin
      a = 4'hF;
      a[idx] = 1'b0;
      d = !(idx == 3 && mState == 2'd3);
      v = (idx == 0) ? mOnes : (idx == 1) ? mTens : mHuns;
      if (idx == 3) sg = 7'b1000110;
      else if (ph == 1 && mState != 2'd3 && int'(mState) == idx) sg = 7'h7F;
      else if (blz && mState == 2'd3 && idx == 2 && mHuns == 0) sg = 7'h7F;
      else if (blz && mState == 2'd3 && idx == 1 && mHuns == 0 && mTens == 0) sg = 7'h7F;
      else sg = glyphTab[v];
    end
    return {sg, d, a, ft};
  endfunction

  task automatic applyStimulus(input logic [3:0] o, input logic [3:0] t, input logic [3:0] h,
                               input logic [1:0] st, input logic blz);
    logic [12:0] exp;
    ones = o; tens = t; huns = h; input_state = st; blank_lz = blz;
    k++;
    expQ.push_back(modelOut(k, blz));
    if (k % FRAME == 0) begin
      mOnes = o; mTens = t; mHuns = h; mState = st;
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("qlen", 32'(expQ.size()), 32'd1);
    if (expQ.size() > 0) begin
      exp = expQ.pop_front();
      checkOutput("seg", 32'(seg), 32'(exp[12:6]));
      checkOutput("dp", 32'(dp), 32'(exp[5]));
      checkOutput("an", 32'(an), 32'(exp[4:1]));
      checkOutput("frame_tick", 32'(frame_tick), 32'(exp[0]));
    end
  endtask

  task automatic runCycles(input int n, input logic [3:0] o, input logic [3:0] t,
                           input logic [3:0] h, input logic [1:0] st, input logic blz);
    for (int i = 0; i < n; i++) applyStimulus(o, t, h, st, blz);
  endtask

  task automatic alignFrame(input logic [3:0] o, input logic [3:0] t,
                            input logic [3:0] h, input logic [1:0] st, input logic blz);
    while (k % FRAME != 0) applyStimulus(o, t, h, st, blz);
  endtask

  task automatic resetModel();
    k = 0;
    mOnes = 4'd0; mTens = 4'd0; mHuns = 4'd0; mState = 2'd0;
    expQ.delete();
  endtask

  initial begin
    glyphTab[0]  = 7'b1000000; glyphTab[1]  = 7'b1111001;
    glyphTab[2]  = 7'b0100100; glyphTab[3]  = 7'b0110000;
    glyphTab[4]  = 7'b0011001; glyphTab[5]  = 7'b0010010;
    glyphTab[6]  = 7'b0000010; glyphTab[7]  = 7'b1111000;
    glyphTab[8]  = 7'b0000000; glyphTab[9]  = 7'b0010000;
    for (int i = 10; i < 16; i++) glyphTab[i] = 7'b0111111;

    rst = 1'b1;
    ones = 4'd1; tens = 4'd2; huns = 4'd3; input_state = 2'd3; blank_lz = 1'b0;
    resetModel();
    #2;
    checkOutput("rst_seg", 32'(seg), 32'h7F);
    checkOutput("rst_an", 32'(an), 32'hF);
    checkOutput("rst_dp", 32'(dp), 32'd1);
    checkOutput("rst_ft", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runCycles(22, 4'd1, 4'd2, 4'd3, 2'd3, 1'b0);

    // Mid-scan reset must blank the outputs without waiting for a clock edge.
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_seg", 32'(seg), 32'h7F);
    checkOutput("mid_rst_an", 32'(an), 32'hF);
    checkOutput("mid_rst_dp", 32'(dp), 32'd1);
    checkOutput("mid_rst_ft", 32'(frame_tick), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    resetModel();

    runCycles(40, 4'd1, 4'd2, 4'd3, 2'd3, 1'b0);
    alignFrame(4'd1, 4'd2, 4'd3, 2'd3, 1'b0);
    runCycles(5, 4'd1, 4'd2, 4'd3, 2'd3, 1'b0);
    runCycles(40, 4'd9, 4'd2, 4'd3, 2'd3, 1'b0);

    runCycles(130, 4'd5, 4'd4, 4'd2, 2'd1, 1'b0);

    runCycles(40, 4'd7, 4'd0, 4'd0, 2'd3, 1'b1);
    runCycles(40, 4'd0, 4'd0, 4'd0, 2'd3, 1'b1);
    runCycles(40, 4'd0, 4'd0, 4'd0, 2'd3, 1'b0);
    runCycles(40, 4'd0, 4'd5, 4'd0, 2'd3, 1'b1);

    runCycles(40, 4'hC, 4'd6, 4'd8, 2'd3, 1'b0);

    alignFrame(4'd3, 4'd0, 4'd1, 2'd0, 1'b1);
    runCycles(90, 4'd3, 4'd0, 4'd1, 2'd0, 1'b1);
    alignFrame(4'd3, 4'd0, 4'd1, 2'd0, 1'b1);
    runCycles(6, 4'd3, 4'd0, 4'd1, 2'd0, 1'b1);
    runCycles(40, 4'd3, 4'd0, 4'd1, 2'd3, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
